pulse_tof_counter: RTL and testbench

Downstream consumer of the single-impulse transmitter stage in the wireless receiver chain. Starts a cycle counter on the rising edge of the transmitted impulse. Ignores the receiver comparator for a blanking window to suppress direct crosstalk. Latches the cycle count at the first synchronized echo rising edge, or flags a timeout, and produces one result per impulse for the propagation-time readout.

---
 rtl/pulse_tof_counter.sv | 167 ++++++++++++++++
 tb/tb_pulse_tof_counter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_tof_counter.sv
// ----------------------------------------------------------------------------
// pulse_tof_counter
//
// Measures the time of flight between a transmitted impulse and the first
// echo seen by the receiver comparator. A cycle counter starts on the rising
// edge of the transmitted impulse. Echo edges are ignored for a short
// blanking window so that direct crosstalk from the transmitter is not
// mistaken for a reflection. The count is latched on the first echo rising
// edge after blanking, or a timeout is flagged if no echo arrives. Each
// impulse yields exactly one result strobe.
//
// Parameters:
//   CNT_WIDTH      width of the cycle counter and o_Count
//   BLANK_CYCLES   cycles after start during which echo edges are ignored
//   TIMEOUT_CYCLES counter value at which a measurement is abandoned
//
// Ports:
//   i_Clk      system clock
//   i_Rst_L    asynchronous active-low reset
//   i_Start    transmitted impulse, synchronous to i_Clk (rising edge starts)
//   i_Echo     raw comparator output, asynchronous to i_Clk
//   o_Count    last measured cycle count, held until the next valid result
//   o_Valid    one-cycle strobe, o_Count was updated
//   o_Timeout  one-cycle strobe, measurement ended without an echo
//   o_Busy     high while a measurement is in progress
//
// The two-cycle echo synchronizer latency is not compensated here; the
// readout side subtracts it from o_Count.
// ----------------------------------------------------------------------------
module pulse_tof_counter #(
   parameter int CNT_WIDTH      = 16,
   parameter int BLANK_CYCLES   = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst_L,
   input  logic                 i_Start,
   input  logic                 i_Echo,
   output logic [CNT_WIDTH-1:0] o_Count,
   output logic                 o_Valid,
   output logic                 o_Timeout,
   output logic                 o_Busy
);

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      MEASURE
   } state_t;

   localparam logic [CNT_WIDTH-1:0] BLANK_VAL   = CNT_WIDTH'(BLANK_CYCLES);
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [CNT_WIDTH-1:0] ONE_VAL     = CNT_WIDTH'(1);

   state_t               r_state;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] r_count;
   logic                 r_valid;
   logic                 r_timeout;
   logic                 r_busy;

   logic                 r_echoSync1;
   logic                 r_echoSync2;
   logic                 r_echoDly;
   logic                 r_startDly;

   logic                 w_echoRise;
   logic                 w_startRise;

   state_t               w_nextState;
   logic [CNT_WIDTH-1:0] w_nextCnt;
   logic [CNT_WIDTH-1:0] w_nextCount;
   logic                 w_nextValid;
   logic                 w_nextTimeout;

   // The echo comes straight from an analog comparator, so it passes through
   // a two-flop synchronizer before anything looks at it. A third flop holds
   // the previous synchronized level so only genuine low-to-high transitions
   // count; an echo that is already high never produces an edge. The start
   // delay flop runs in every state so that a start level held high across
   // the return to IDLE cannot look like a fresh edge.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_echoSync1 <= 1'b0;
         r_echoSync2 <= 1'b0;
         r_echoDly   <= 1'b0;
         r_startDly  <= 1'b0;
      end else begin
         r_echoSync1 <= i_Echo;
         r_echoSync2 <= r_echoSync1;
         r_echoDly   <= r_echoSync2;
         r_startDly  <= i_Start;
      end
   end

   assign w_echoRise  = r_echoSync2 & ~r_echoDly;
   assign w_startRise = i_Start & ~r_startDly;

   // Next-state and result logic. The counter reaches 1 on the start edge and
   // then counts edges, so its value always equals the number of edges since
   // start. In MEASURE the counter freezes on the terminating edge, which
   // keeps it from ever passing the timeout value. An echo on the very edge
   // where the timeout would fire still counts as a valid result.
   always_comb begin
      w_nextState   = r_state;
      w_nextCnt     = r_cnt;
      w_nextCount   = r_count;
      w_nextValid   = 1'b0;
      w_nextTimeout = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_startRise) begin
               w_nextCnt   = ONE_VAL;
               w_nextState = BLANK;
            end
         end
         BLANK: begin
            w_nextCnt = r_cnt + ONE_VAL;
            if (r_cnt == BLANK_VAL) begin
               w_nextState = MEASURE;
            end
         end
         MEASURE: begin
            if (w_echoRise) begin
               w_nextCount = r_cnt;
               w_nextValid = 1'b1;
               w_nextState = IDLE;
            end else if (r_cnt == TIMEOUT_VAL) begin
               w_nextTimeout = 1'b1;
               w_nextState   = IDLE;
            end else begin
               w_nextCnt = r_cnt + ONE_VAL;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State and output registers. Busy is registered alongside the state so
   // it drops on the same edge that the result strobe rises. Reset aborts a
   // measurement in progress without producing any strobe.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_count   <= '0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_cnt     <= w_nextCnt;
         r_count   <= w_nextCount;
         r_valid   <= w_nextValid;
         r_timeout <= w_nextTimeout;
         r_busy    <= (w_nextState != IDLE);
      end
   end

   assign o_Count   = r_count;
   assign o_Valid   = r_valid;
   assign o_Timeout = r_timeout;
   assign o_Busy    = r_busy;

endmodule

// File: tb/tb_pulse_tof_counter.sv
// ----------------------------------------------------------------------------
// tb_pulse_tof_counter
//
// Directed bench for pulse_tof_counter with BLANK_CYCLES=8 and
// TIMEOUT_CYCLES=100. Each measurement is driven cycle by cycle relative to
// the start edge T0; index j means "the edge T0+j". An input assigned at
// index j is set just after edge T0+j-1 and is seen by edge T0+j. Outputs
// are sampled 1 ns after each edge.
// ----------------------------------------------------------------------------
module tb_pulse_tof_counter;

   localparam int CNT_WIDTH      = 16;
   localparam int BLANK_CYCLES   = 8;
   localparam int TIMEOUT_CYCLES = 100;

   logic                 i_Clk;
   logic                 i_Rst_L;
   logic                 i_Start;
   logic                 i_Echo;
   logic [CNT_WIDTH-1:0] o_Count;
   logic                 o_Valid;
   logic                 o_Timeout;
   logic                 o_Busy;

   int testsRun;
   int testsFailed;

   int validCnt;
   int timeoutCnt;
   int bothCnt;
   int validEdge;
   int timeoutEdge;
   int validValue;
   int lastBusyEdge;
   int busyAtStart;

   pulse_tof_counter #(
      .CNT_WIDTH      (CNT_WIDTH),
      .BLANK_CYCLES   (BLANK_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .i_Clk     (i_Clk),
      .i_Rst_L   (i_Rst_L),
      .i_Start   (i_Start),
      .i_Echo    (i_Echo),
      .o_Count   (o_Count),
      .o_Valid   (o_Valid),
      .o_Timeout (o_Timeout),
      .o_Busy    (o_Busy)
   );

   // 100 MHz simulation clock; only the cycle count matters here.
   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      testsRun++;
      if (observed != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge i_Clk);
      #1;
   endtask

   // Drive one measurement and record every strobe seen along the way.
   // Negative indices disable the corresponding event.
   task automatic applyStimulus(input int startWidth, input int restartK,
                                input int echoOnK, input int echoOffK,
                                input int echo2K, input int cycles);
      validCnt     = 0;
      timeoutCnt   = 0;
      validEdge    = -1;
      timeoutEdge  = -1;
      validValue   = -1;
      lastBusyEdge = -1;
      busyAtStart  = 0;
      for (int j = 0; j < cycles; j++) begin
         if (j == 0) i_Start = 1'b1;
         if (j == startWidth) i_Start = 1'b0;
         if (j == restartK) i_Start = 1'b1;
         if (restartK >= 0 && j == restartK + 8) i_Start = 1'b0;
         if (j == echoOffK) i_Echo = 1'b0;
         if (j == echoOnK) i_Echo = 1'b1;
         if (j == echo2K) i_Echo = 1'b1;
         tick();
         if (j == 0) busyAtStart = int'(o_Busy);
         if (o_Busy) lastBusyEdge = j;
         if (o_Valid && o_Timeout) bothCnt++;
         if (o_Valid) begin
            validCnt++;
            validEdge  = j;
            validValue = int'(o_Count);
         end
         if (o_Timeout) begin
            timeoutCnt++;
            timeoutEdge = j;
         end
      end
      i_Start = 1'b0;
   endtask

   // Quiet cycles between measurements; echo returns low.
   task automatic idleGap();
      i_Start = 1'b0;
      i_Echo  = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      bothCnt     = 0;
      i_Rst_L     = 1'b0;
      i_Start     = 1'b0;
      i_Echo      = 1'b0;
      repeat (3) tick();
      checkOutput("reset_count",   int'(o_Count),   0);
      checkOutput("reset_valid",   int'(o_Valid),   0);
      checkOutput("reset_timeout", int'(o_Timeout), 0);
      checkOutput("reset_busy",    int'(o_Busy),    0);
      i_Rst_L = 1'b1;
      repeat (2) tick();

      // Echo rising before T0+40 gives a count of 42.
      applyStimulus(8, -1, 40, -1, -1, 50);
      checkOutput("t1_busy_start", busyAtStart, 1);
      checkOutput("t1_valid_cnt",  validCnt,    1);
      checkOutput("t1_value",      validValue,  42);
      checkOutput("t1_valid_edge", validEdge,   42);
      checkOutput("t1_busy_fall",  lastBusyEdge, 41);
      checkOutput("t1_timeouts",   timeoutCnt,  0);
      checkOutput("t1_hold",       int'(o_Count), 42);
      idleGap();

      // No echo: timeout at T0+100, previous count retained.
      applyStimulus(8, -1, -1, -1, -1, 105);
      checkOutput("t3_timeout_cnt",  timeoutCnt,  1);
      checkOutput("t3_timeout_edge", timeoutEdge, 100);
      checkOutput("t3_valids",       validCnt,    0);
      checkOutput("t3_count_kept",   int'(o_Count), 42);
      checkOutput("t3_busy_fall",    lastBusyEdge, 99);
      idleGap();

      // Crosstalk pulse inside blanking is ignored; real echo at k=20.
      applyStimulus(8, -1, 3, 5, 20, 30);
      checkOutput("t2_valid_cnt",  validCnt,   1);
      checkOutput("t2_value",      validValue, 22);
      checkOutput("t2_valid_edge", validEdge,  22);
      idleGap();

      // Second start edge mid-measurement is ignored.
      applyStimulus(8, 30, 50, -1, -1, 60);
      checkOutput("t4_valid_cnt", validCnt,   1);
      checkOutput("t4_value",     validValue, 52);
      checkOutput("t4_timeouts",  timeoutCnt, 0);
      checkOutput("t4_busy_fall", lastBusyEdge, 51);
      idleGap();

      // Echo already high and held: no edge in MEASURE, so timeout.
      applyStimulus(8, -1, 2, -1, -1, 105);
      checkOutput("t5_timeout_cnt",  timeoutCnt,  1);
      checkOutput("t5_timeout_edge", timeoutEdge, 100);
      checkOutput("t5_valids",       validCnt,    0);
      idleGap();

      // Echo edge lands exactly on the timeout edge: echo wins.
      applyStimulus(8, -1, 98, -1, -1, 105);
      checkOutput("t7_valid_cnt",  validCnt,   1);
      checkOutput("t7_value",      validValue, 100);
      checkOutput("t7_valid_edge", validEdge,  100);
      checkOutput("t7_timeouts",   timeoutCnt, 0);
      idleGap();

      // Echo edge on the last blanking edge (T0+8) is ignored.
      applyStimulus(8, -1, 6, -1, -1, 105);
      checkOutput("t8_timeout_cnt", timeoutCnt, 1);
      checkOutput("t8_valids",      validCnt,   0);
      idleGap();

      // Echo edge on the first measuring edge (T0+9) is accepted.
      applyStimulus(8, -1, 7, -1, -1, 20);
      checkOutput("t9_valid_cnt", validCnt,   1);
      checkOutput("t9_value",     validValue, 9);
      idleGap();

      // Start held high past the result must not retrigger.
      applyStimulus(30, -1, 10, -1, -1, 40);
      checkOutput("t10_valid_cnt", validCnt,     1);
      checkOutput("t10_value",     validValue,   12);
      checkOutput("t10_busy_fall", lastBusyEdge, 11);
      checkOutput("t10_timeouts",  timeoutCnt,   0);
      idleGap();

      // Reset in the middle of MEASURE aborts without any strobe.
      applyStimulus(8, -1, -1, -1, -1, 60);
      checkOutput("t6_pre_strobes", validCnt + timeoutCnt, 0);
      checkOutput("t6_pre_busy",    int'(o_Busy), 1);
      i_Rst_L = 1'b0;
      #1;
      checkOutput("t6_rst_busy",    int'(o_Busy),    0);
      checkOutput("t6_rst_count",   int'(o_Count),   0);
      checkOutput("t6_rst_valid",   int'(o_Valid),   0);
      checkOutput("t6_rst_timeout", int'(o_Timeout), 0);
      repeat (2) tick();
      i_Rst_L = 1'b1;
      repeat (2) tick();
      checkOutput("t6_idle_busy", int'(o_Busy), 0);
      applyStimulus(8, -1, 15, -1, -1, 25);
      checkOutput("t6_valid_cnt",  validCnt,   1);
      checkOutput("t6_value",      validValue, 17);
      checkOutput("t6_valid_edge", validEdge,  17);
      idleGap();

      checkOutput("never_both_strobes", bothCnt, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
